mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-ported unified memory between the instruction-fetch requester and the load/store requester of the ARC MIPS core. It accepts one request per cycle under a valid/ready handshake, tracks in-flight accesses through a fixed-latency tag pipeline and routes each read response back to its originator. Data accesses have priority, with a starvation guard for fetch, and a flush input discards in-flight fetches after a PC redirect. It sits between the `fetch` stage / memory stage and the external memory port of `core`.

## Interface

Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: cycles from accept to read data on `i_mem_rdata`. Legal range is 1..4.
- `MAX_DBURST`, 4: maximum consecutive data grants while fetch is waiting.

Ports (clock and reset first):
- `i_clk`  in  1  core clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_ireq_valid`  in  1  fetch request.
- `i_ireq_addr`  in  ADDR_W  fetch address.
- `o_ireq_ready`  out  1  fetch request accepted this cycle.
- `o_irsp_valid`  out  1  instruction word valid.
- `o_irsp_data`  out  DATA_W  instruction word.
- `i_dreq_valid`  in  1  load/store request.
- `i_dreq_we`  in  1  1 = store.
- `i_dreq_addr`  in  ADDR_W  data address.
- `i_dreq_wdata`  in  DATA_W  store data.
- `o_dreq_ready`  out  1  data request accepted this cycle.
- `o_drsp_valid`  out  1  load data or store acknowledge.
- `o_drsp_data`  out  DATA_W  load data; 0 for stores.
- `i_flush`  in  1  kill all in-flight fetch responses.
- `o_mem_en`, `o_mem_we`  out  1  memory strobe and write enable.
- `o_mem_addr`  out  ADDR_W  memory address.
- `o_mem_wdata`  out  DATA_W  memory write data.
- `i_mem_rdata`  in  DATA_W  memory read data, `MEM_LAT` cycles after strobe.
- `o_stall`  out  1  a valid request was not granted this cycle.

## Operation

- **Arbitration** is combinational each cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: data wins, unless `dstreak == MAX_DBURST`, in which case fetch wins.
- **`dstreak` counter:**
  - Increments on a data grant while `i_ireq_valid` = 1.
  - Clears on any fetch grant, or whenever `i_ireq_valid` = 0.
  - Saturates at `MAX_DBURST`.
- **Acceptance:** a request is accepted when valid && ready. At most one ready is high per cycle.
- **Memory port:** `o_mem_*` are driven combinationally from the granted request. `o_mem_en` = 1 only on accept, and all `o_mem_*` are 0 otherwise.
- **Tag pipeline:** each accept pushes the tag {valid, src, we, killed=0} into a `MEM_LAT`-deep shift register.
  - At the output stage, a valid instr tag with killed = 0 asserts `o_irsp_valid` and `o_irsp_data` = `i_mem_rdata`.
  - A valid data tag asserts `o_drsp_valid`. Load data is taken from `i_mem_rdata`; store data is 0.
- **Flush:** `i_flush` sets killed on every in-flight instr tag present before the edge. A fetch accepted in the same cycle as the flush is not killed. Data tags are never killed.
- **Response handshake:** responses have no backpressure. Requesters must always sink them.
- **`o_stall`:** equals (`i_ireq_valid` && !`o_ireq_ready`) || (`i_dreq_valid` && !`o_dreq_ready`).

## Timing

- Accept at edge T → response valid in the cycle following edge T+`MEM_LAT`−1; that is, `MEM_LAT`=1 gives a response in the cycle after accept.
- Throughput is one access per cycle, with back-to-back accepts from either source.
- **Reset** (asynchronous assert, synchronous-safe deassert):
  - All tags are cleared and `dstreak` = 0.
  - `o_irsp_valid`, `o_drsp_valid`, `o_mem_en` = 0, and data outputs are 0.
  - Reset mid-operation drops in-flight accesses; no response is issued after release.
- **Request stability:** a requester held off by arbitration keeps valid and its payload stable until accepted. The arbiter does not latch payloads.
- **Response ordering:** responses leave in accept order. Simultaneous instr and data responses are impossible, since there is one tag per cycle.

## Structure

- Package `arc_pkg`:
  - `typedef enum logic [1:0] {SRC_NONE, SRC_INSTR, SRC_DATA} mem_src_e`.
  - `typedef struct packed {logic valid; mem_src_e src; logic we; logic killed;} mem_tag_t`.
  - `localparam MEM_LAT_MAX = 4`.
- Sub-module `mem_tag_pipe`: parameterised delay line of `mem_tag_t`, with flush-kill input and output-stage tag. The arbiter adds grant logic, `dstreak` and response muxing.

## Test plan

- **Fetch only:** `MEM_LAT`=1, `i_ireq_valid` held with addresses 0x0, 0x4, 0x8 and memory returning addr+0x100 → `o_ireq_ready`=1 every cycle; `o_irsp_data` = 0x100, 0x104, 0x108 on consecutive cycles, each one cycle after accept.
- **Store priority:** fetch 0x40 and store (0x80, 0xDEADBEEF) valid together → store granted first with `o_mem_we`=1 and `o_stall`=1; fetch granted next cycle; `o_drsp_valid` with data 0, then `o_irsp_valid`.
- **Starvation guard:** `MAX_DBURST`=4, both valid continuously → grant pattern D,D,D,D,I,D,D,D,D,I.
- **Flush:** `MEM_LAT`=3, fetches accepted at cycles 0, 1, 2, flush asserted in cycle 2 → only the cycle-2 fetch responds; no response for cycles 0 and 1.
- **Reset mid-flight:** `MEM_LAT`=2, load accepted, `i_rst_n` pulsed low next cycle → `o_drsp_valid` never asserts; all outputs 0 during reset; first post-reset request behaves normally.
- **Latency sweep:** `MEM_LAT`=4, interleaved loads and fetches → every response appears exactly 4 cycles after its accept and is routed to the correct port.

Source files
------------

// File: rtl/arc_pkg.sv
// Shared types for the unified-memory arbiter: requester source encoding and
// the per-access tag that travels alongside each memory access.
package arc_pkg;

    typedef enum logic [1:0] {SRC_NONE, SRC_INSTR, SRC_DATA} mem_src_e;

    typedef struct packed {
        logic     valid;
        mem_src_e src;
        logic     we;
        logic     killed;
    } mem_tag_t;

    localparam int MEM_LAT_MAX = 4;

    localparam mem_tag_t TAG_NONE = '0;

    // A redirect only invalidates instruction fetches; data accesses always complete.
    function automatic mem_tag_t kill_instr(input mem_tag_t tag, input logic flush);
        mem_tag_t t;
        t = tag;
        if (flush && tag.valid && (tag.src == SRC_INSTR)) begin
            t.killed = 1'b1;
        end
        return t;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch/load-store request and response signals plus the external
// memory port, shared between the core requesters and mem_arbiter.
// Handshake: a request transfers on any cycle where valid && ready; responses are
// single-cycle valid pulses with no backpressure and must always be sunk.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_ireq_valid;
    logic [ADDR_W-1:0] i_ireq_addr;
    logic              o_ireq_ready;
    logic              o_irsp_valid;
    logic [DATA_W-1:0] o_irsp_data;
    logic              i_dreq_valid;
    logic              i_dreq_we;
    logic [ADDR_W-1:0] i_dreq_addr;
    logic [DATA_W-1:0] i_dreq_wdata;
    logic              o_dreq_ready;
    logic              o_drsp_valid;
    logic [DATA_W-1:0] o_drsp_data;
    logic              i_flush;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_stall;

    modport slave (
        input  i_ireq_valid, i_ireq_addr, i_dreq_valid, i_dreq_we, i_dreq_addr,
               i_dreq_wdata, i_flush, i_mem_rdata,
        output o_ireq_ready, o_irsp_valid, o_irsp_data, o_dreq_ready, o_drsp_valid,
               o_drsp_data, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_stall
    );

    modport master (
        output i_ireq_valid, i_ireq_addr, i_dreq_valid, i_dreq_we, i_dreq_addr,
               i_dreq_wdata, i_flush, i_mem_rdata,
        input  o_ireq_ready, o_irsp_valid, o_irsp_data, o_dreq_ready, o_drsp_valid,
               o_drsp_data, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_stall
    );

endinterface

// File: rtl/mem_tag_pipe.sv
// Fixed-latency delay line of access tags; a flush marks every in-flight
// instruction tag as killed while the newly pushed tag enters clean.
module mem_tag_pipe
    import arc_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  mem_tag_t i_tag,
    input  logic     i_flush,
    output mem_tag_t o_tag
);

    mem_tag_t r_stage [MEM_LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < MEM_LAT; k++) begin
                r_stage[k] <= TAG_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_stage[k] <= kill_instr(r_stage[k-1], i_flush);
            end
        end
    end

    // The tag leaving the last stage lines up with the memory read data.
    assign o_tag = r_stage[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto the single-ported memory,
// with data priority, a fetch starvation guard and tagged response routing.
module mem_arbiter
    import arc_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_DBURST = 4
) (
    input logic          i_clk,
    input logic          i_rst_n,
    mem_arbiter_if.slave i_bus
);

    localparam int SW = (MAX_DBURST < 1) ? 1 : $clog2(MAX_DBURST + 1);
    localparam logic [SW-1:0] DBURST_MAX = SW'(MAX_DBURST);

    logic [SW-1:0]     r_dstreak;
    logic              w_starved;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_irsp;
    logic              w_drsp;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    mem_tag_t          w_push_tag;
    mem_tag_t          w_out_tag;

    // Grants are held off while reset is asserted so the memory strobe stays quiet.
    always_comb begin
        w_starved = (r_dstreak == DBURST_MAX);
        w_grant_d = i_rst_n && i_bus.i_dreq_valid && (!i_bus.i_ireq_valid || !w_starved);
        w_grant_i = i_rst_n && i_bus.i_ireq_valid && (!i_bus.i_dreq_valid || w_starved);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dstreak <= '0;
        end else if (!i_bus.i_ireq_valid || w_grant_i) begin
            r_dstreak <= '0;
        end else if (w_grant_d && !w_starved) begin
            r_dstreak <= r_dstreak + SW'(1);
        end
    end

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_push_tag  = TAG_NONE;
        if (w_grant_d) begin
            w_mem_addr  = i_bus.i_dreq_addr;
            w_mem_wdata = i_bus.i_dreq_we ? i_bus.i_dreq_wdata : '0;
            w_push_tag  = '{valid: 1'b1, src: SRC_DATA, we: i_bus.i_dreq_we, killed: 1'b0};
        end else if (w_grant_i) begin
            w_mem_addr  = i_bus.i_ireq_addr;
            w_push_tag  = '{valid: 1'b1, src: SRC_INSTR, we: 1'b0, killed: 1'b0};
        end
    end

    assign i_bus.o_ireq_ready = w_grant_i;
    assign i_bus.o_dreq_ready = w_grant_d;
    assign i_bus.o_mem_en     = w_grant_i || w_grant_d;
    assign i_bus.o_mem_we     = w_grant_d && i_bus.i_dreq_we;
    assign i_bus.o_mem_addr   = w_mem_addr;
    assign i_bus.o_mem_wdata  = w_mem_wdata;
    assign i_bus.o_stall      = (i_bus.i_ireq_valid && !w_grant_i) ||
                                (i_bus.i_dreq_valid && !w_grant_d);

    mem_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tag   (w_push_tag),
        .i_flush (i_bus.i_flush),
        .o_tag   (w_out_tag)
    );

    always_comb begin
        w_irsp = w_out_tag.valid && (w_out_tag.src == SRC_INSTR) && !w_out_tag.killed;
        w_drsp = w_out_tag.valid && (w_out_tag.src == SRC_DATA);
    end

    // Stores acknowledge with zero data rather than whatever the memory drives.
    assign i_bus.o_irsp_valid = w_irsp;
    assign i_bus.o_irsp_data  = w_irsp ? i_bus.i_mem_rdata : '0;
    assign i_bus.o_drsp_valid = w_drsp;
    assign i_bus.o_drsp_data  = (w_drsp && !w_out_tag.we) ? i_bus.i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (latency 1 and 4) share one
// stimulus stream; accepted requests queue expected responses checked on output.
module tb_mem_arbiter;
    import arc_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // shared stimulus
    logic          ivalid, dvalid, dwe, flush;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dwdata;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();

    assign bus1.i_ireq_valid = ivalid;
    assign bus1.i_ireq_addr  = iaddr;
    assign bus1.i_dreq_valid = dvalid;
    assign bus1.i_dreq_we    = dwe;
    assign bus1.i_dreq_addr  = daddr;
    assign bus1.i_dreq_wdata = dwdata;
    assign bus1.i_flush      = flush;
    assign bus4.i_ireq_valid = ivalid;
    assign bus4.i_ireq_addr  = iaddr;
    assign bus4.i_dreq_valid = dvalid;
    assign bus4.i_dreq_we    = dwe;
    assign bus4.i_dreq_addr  = daddr;
    assign bus4.i_dreq_wdata = dwdata;
    assign bus4.i_flush      = flush;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_DBURST(4)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_bus   (bus1)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(4), .MAX_DBURST(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_bus   (bus4)
    );

    // memory models: read data is the strobed address + 0x100, after the latency
    logic [AW-1:0] m1_q;
    logic [AW-1:0] m4_q [4];
    always @(posedge clk) begin
        m1_q    <= bus1.o_mem_addr;
        m4_q[0] <= bus4.o_mem_addr;
        for (int k = 1; k < 4; k++) m4_q[k] <= m4_q[k-1];
    end
    assign bus1.i_mem_rdata = m1_q + 32'h100;
    assign bus4.i_mem_rdata = m4_q[3] + 32'h100;

    // scoreboard: {is_data, data, due_cycle}
    logic [48:0] exp1_q[$];
    logic [48:0] exp4_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [48:0] mk(input logic is_d, input logic [31:0] data, input int due);
        return {is_d, data, due[15:0]};
    endfunction

    // expectation producer: records accepted requests and applies flush kills
    logic [31:0] d_exp;
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                for (int k = exp1_q.size() - 1; k >= 0; k--)
                    if (!exp1_q[k][48] && (exp1_q[k][15:0] > cyc[15:0])) exp1_q.delete(k);
                for (int k = exp4_q.size() - 1; k >= 0; k--)
                    if (!exp4_q[k][48] && (exp4_q[k][15:0] > cyc[15:0])) exp4_q.delete(k);
            end
            if (bus1.o_ireq_ready) begin
                exp1_q.push_back(mk(1'b0, iaddr + 32'h100, cyc + 1));
                exp4_q.push_back(mk(1'b0, iaddr + 32'h100, cyc + 4));
            end
            if (bus1.o_dreq_ready) begin
                d_exp = dwe ? 32'h0 : daddr + 32'h100;
                exp1_q.push_back(mk(1'b1, d_exp, cyc + 1));
                exp4_q.push_back(mk(1'b1, d_exp, cyc + 4));
            end
        end
    end

    // monitors
    logic [48:0] e1, e4;
    always @(negedge clk) begin
        if (bus1.o_irsp_valid || bus1.o_drsp_valid) begin
            if (exp1_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lat1 response: got a response at cycle %0d, expected none", cyc);
            end else begin
                e1 = exp1_q.pop_front();
                check("lat1 port", bus1.o_drsp_valid, e1[48]);
                check("lat1 data", bus1.o_drsp_valid ? bus1.o_drsp_data : bus1.o_irsp_data, e1[47:16]);
                check("lat1 cycle", cyc[15:0], e1[15:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (bus4.o_irsp_valid || bus4.o_drsp_valid) begin
            if (exp4_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lat4 response: got a response at cycle %0d, expected none", cyc);
            end else begin
                e4 = exp4_q.pop_front();
                check("lat4 port", bus4.o_drsp_valid, e4[48]);
                check("lat4 data", bus4.o_drsp_valid ? bus4.o_drsp_data : bus4.o_irsp_data, e4[47:16]);
                check("lat4 cycle", cyc[15:0], e4[15:0]);
            end
        end
    end

    // driver tasks
    task automatic idle();
        ivalid = 1'b0; dvalid = 1'b0; dwe = 1'b0; flush = 1'b0;
        iaddr = '0; daddr = '0; dwdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " lat1 strobes"}, {bus1.o_irsp_valid, bus1.o_drsp_valid, bus1.o_mem_en, bus1.o_mem_we}, 4'b0);
        check({tag, " lat1 data"}, {bus1.o_irsp_data, bus1.o_drsp_data}, 64'h0);
        check({tag, " lat1 mem bus"}, {bus1.o_mem_addr, bus1.o_mem_wdata}, 64'h0);
        check({tag, " lat4 strobes"}, {bus4.o_irsp_valid, bus4.o_drsp_valid, bus4.o_mem_en, bus4.o_mem_we}, 4'b0);
        check({tag, " lat4 data"}, {bus4.o_irsp_data, bus4.o_drsp_data}, 64'h0);
        check({tag, " lat4 mem bus"}, {bus4.o_mem_addr, bus4.o_mem_wdata}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    logic       g_d;
    logic [9:0] pat;

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // fetch only
        ivalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iaddr = 32'(k * 4);
            @(negedge clk);
            check($sformatf("fetch ready %0d", k), bus1.o_ireq_ready, 1'b1);
            check($sformatf("fetch stall %0d", k), bus1.o_stall, 1'b0);
            next_cycle();
        end
        idle();
        drain();

        // store priority over fetch
        ivalid = 1'b1; iaddr = 32'h40;
        dvalid = 1'b1; dwe = 1'b1; daddr = 32'h80; dwdata = 32'hDEADBEEF;
        @(negedge clk);
        check("prio store ready", {bus1.o_dreq_ready, bus1.o_ireq_ready}, 2'b10);
        check("prio store we", bus1.o_mem_we, 1'b1);
        check("prio store addr", bus1.o_mem_addr, 32'h80);
        check("prio store wdata", bus1.o_mem_wdata, 32'hDEADBEEF);
        check("prio store stall", bus1.o_stall, 1'b1);
        next_cycle();
        dvalid = 1'b0; dwe = 1'b0;
        @(negedge clk);
        check("prio fetch ready", {bus1.o_dreq_ready, bus1.o_ireq_ready}, 2'b01);
        check("prio fetch addr", {bus1.o_mem_we, bus1.o_mem_addr}, {1'b0, 32'h40});
        check("prio fetch stall", bus1.o_stall, 1'b0);
        next_cycle();
        idle();
        drain();

        // starvation guard: D,D,D,D,I,D,D,D,D,I
        pat = 10'b1111011110;
        ivalid = 1'b1; iaddr = 32'h480;
        dvalid = 1'b1; daddr = 32'h400;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            g_d = bus1.o_dreq_ready;
            check($sformatf("burst grant %0d", k), g_d, pat[9-k]);
            check($sformatf("burst stall %0d", k), bus1.o_stall, 1'b1);
            next_cycle();
            if (g_d) daddr = daddr + 32'h4;
            else     iaddr = iaddr + 32'h4;
        end
        idle();
        drain();

        // flush kills older fetches; the same-cycle fetch survives
        ivalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iaddr = 32'h200 + 32'(k * 4);
            flush = (k == 2);
            @(negedge clk);
            check($sformatf("flush fetch ready %0d", k), bus1.o_ireq_ready, 1'b1);
            next_cycle();
        end
        idle();
        drain();

        // reset in flight drops the pending load
        dvalid = 1'b1; daddr = 32'h300;
        next_cycle();
        idle();
        rst_n = 1'b0;
        exp1_q.delete();
        exp4_q.delete();
        @(negedge clk);
        check_quiet("midreset a");
        next_cycle();
        @(negedge clk);
        check_quiet("midreset b");
        rst_n = 1'b1;
        next_cycle();
        ivalid = 1'b1; iaddr = 32'h500;
        @(negedge clk);
        check("post reset ready", bus1.o_ireq_ready, 1'b1);
        next_cycle();
        idle();
        drain();

        // latency sweep: alternating fetches and loads
        for (int k = 0; k < 6; k++) begin
            idle();
            if (k % 2 == 0) begin
                ivalid = 1'b1; iaddr = 32'h600 + 32'(k * 4);
            end else begin
                dvalid = 1'b1; daddr = 32'h700 + 32'(k * 4);
            end
            @(negedge clk);
            check($sformatf("sweep mem_en %0d", k), bus4.o_mem_en, 1'b1);
            next_cycle();
        end
        idle();
        drain();
        drain();

        check("lat1 queue drained", exp1_q.size(), 0);
        check("lat4 queue drained", exp4_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
